pc_sequencer: RTL and testbench

Program-counter and run-control stage directly upstream of the ALU. It holds the instruction address and advances it each cycle. It applies the signed branch offset the ALU produces for the branch op, and acts on the ALU's reset/halt requests. It also runs the top-level start/done handshake and counts executed cycles for the bench.

---
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and IDLE/RUN/HALTED run control directly ahead of the ALU, plus a RUN-cycle counter.
// The next PC is visible one cycle after its inputs are sampled; STALL holds the PC and there is no other backpressure.
module pc_sequencer #(
    parameter int              PC_W     = 10,
    parameter int              CNT_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [PC_W-1:0]  PROG_BASE,
    input  logic             BRANCH,
    input  logic [3:0]       bOFFSET,
    input  logic             bSIGN,
    input  logic             SOFT_RST,
    input  logic             HALT_REQ,
    input  logic             STALL,
    output logic [PC_W-1:0]  PC,
    output logic             RUNNING,
    output logic             DONE,
    output logic [CNT_W-1:0] CYCLES
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_nxt;
    logic [PC_W-1:0]  offset_ext;
    logic [PC_W-1:0]  pc_fwd;
    logic [PC_W-1:0]  pc_bwd;
    logic [PC_W-1:0]  pc_inc;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] cyc_nxt;
    logic [CNT_W-1:0] cyc_sat;

    // Modulo-2^PC_W arithmetic: wrap-around past either end of memory is silent.
    assign offset_ext = PC_W'(bOFFSET);
    assign pc_fwd     = pc_q + offset_ext;
    assign pc_bwd     = pc_q - offset_ext;
    assign pc_inc     = pc_q + PC_W'(1);
    assign cyc_sat    = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
            cyc_q <= '0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            cyc_q <= cyc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        cyc_nxt   = cyc_q;
        case (state)
            IDLE, HALTED: begin
                if (START) begin
                    state_nxt = RUN;
                    pc_nxt    = PROG_BASE;
                    cyc_nxt   = '0;
                end
            end
            RUN: begin
                // Every RUN cycle counts, including stalls and the halting cycle itself.
                cyc_nxt = cyc_sat;
                if (SOFT_RST && HALT_REQ) begin
                    state_nxt = HALTED;
                end else if (SOFT_RST) begin
                    pc_nxt = PROG_BASE;
                end else if (STALL) begin
                    pc_nxt = pc_q;
                end else if (BRANCH) begin
                    pc_nxt = bSIGN ? pc_bwd : pc_fwd;
                end else begin
                    pc_nxt = pc_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign PC      = pc_q;
    assign RUNNING = (state == RUN);
    assign DONE    = (state == HALTED);
    assign CYCLES  = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer (CNT_W=4 so counter saturation is reachable quickly).
module tb_pc_sequencer;

    localparam int PC_W  = 10;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             running;
        logic             done;
        logic [CNT_W-1:0] cycles;
    } obs_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [PC_W-1:0]  prog_base;
    logic             branch;
    logic [3:0]       b_offset;
    logic             b_sign;
    logic             soft_rst;
    logic             halt_req;
    logic             stall;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] cycles;

    int n_chk  = 0;
    int n_pass = 0;

    obs_t  exp_q[$];
    string nm_q[$];

    pc_sequencer #(
        .PC_W    (PC_W),
        .CNT_W   (CNT_W),
        .RESET_PC('0)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .START    (start),
        .PROG_BASE(prog_base),
        .BRANCH   (branch),
        .bOFFSET  (b_offset),
        .bSIGN    (b_sign),
        .SOFT_RST (soft_rst),
        .HALT_REQ (halt_req),
        .STALL    (stall),
        .PC       (pc),
        .RUNNING  (running),
        .DONE     (done),
        .CYCLES   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input obs_t exp_v);
        obs_t act;
        act = {pc, running, done, cycles};
        n_chk++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h running=%b done=%b cycles=%0d, want pc=%h running=%b done=%b cycles=%0d",
                     nm, act.pc, act.running, act.done, act.cycles,
                     exp_v.pc, exp_v.running, exp_v.done, exp_v.cycles);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input string nm,
                        input logic st, input logic sr, input logic hr, input logic sl,
                        input logic br, input logic [3:0] off, input logic sg,
                        input logic [PC_W-1:0] base,
                        input logic [PC_W-1:0] e_pc, input logic e_run, input logic e_done,
                        input logic [CNT_W-1:0] e_cyc);
        obs_t e;
        @(negedge clk);
        start     = st;
        soft_rst  = sr;
        halt_req  = hr;
        stall     = sl;
        branch    = br;
        b_offset  = off;
        b_sign    = sg;
        prog_base = base;
        e = {e_pc, e_run, e_done, e_cyc};
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // Monitor: after each rising edge, score every expectation queued for it.
    initial begin
        obs_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                check(n, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion before 100000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; soft_rst = 1'b0; halt_req = 1'b0; stall = 1'b0;
        branch = 1'b0; b_offset = 4'd0; b_sign = 1'b0; prog_base = 10'h010;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Reset, start, straight-line run
        step("idle_after_rst", 0,0,0,0, 0,4'd0,0, 10'h010, 10'h000,0,0,4'd0);
        step("start_010",      1,0,0,0, 0,4'd0,0, 10'h010, 10'h010,1,0,4'd0);
        step("run1",           0,0,0,0, 0,4'd0,0, 10'h010, 10'h011,1,0,4'd1);
        step("run2",           0,0,0,0, 0,4'd0,0, 10'h010, 10'h012,1,0,4'd2);
        step("run3",           0,0,0,0, 0,4'd0,0, 10'h010, 10'h013,1,0,4'd3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", '0);
        step("rst_with_start", 1,0,0,0, 0,4'd0,0, 10'h010, 10'h000,0,0,4'd0);
        step("rst_hold",       0,0,0,0, 0,4'd0,0, 10'h010, 10'h000,0,0,4'd0);
        rst = 1'b0;

        // Branches
        step("start_020",      1,0,0,0, 0,4'd0,0, 10'h020, 10'h020,1,0,4'd0);
        step("br_fwd5",        0,0,0,0, 1,4'd5,0, 10'h020, 10'h025,1,0,4'd1);
        step("br_bwd5",        0,0,0,0, 1,4'd5,1, 10'h020, 10'h020,1,0,4'd2);
        step("br_not_taken",   0,0,0,0, 1,4'd1,0, 10'h020, 10'h021,1,0,4'd3);
        step("br_fwd0",        0,0,0,0, 1,4'd0,0, 10'h020, 10'h021,1,0,4'd4);

        // Wrap-around
        step("soft_to_3fe",    0,1,0,0, 0,4'd0,0, 10'h3FE, 10'h3FE,1,0,4'd5);
        step("wrap_fwd4",      0,0,0,0, 1,4'd4,0, 10'h3FE, 10'h002,1,0,4'd6);
        step("br_bwd1",        0,0,0,0, 1,4'd1,1, 10'h3FE, 10'h001,1,0,4'd7);
        step("wrap_bwd3",      0,0,0,0, 1,4'd3,1, 10'h3FE, 10'h3FE,1,0,4'd8);
        step("inc_3ff",        0,0,0,0, 0,4'd0,0, 10'h3FE, 10'h3FF,1,0,4'd9);
        step("inc_wrap",       0,0,0,0, 0,4'd0,0, 10'h3FE, 10'h000,1,0,4'd10);

        // Priority, ignored inputs, saturation
        step("stall_br1",      0,0,0,1, 1,4'd5,0, 10'h3FE, 10'h000,1,0,4'd11);
        step("stall_br2",      0,0,0,1, 1,4'd5,0, 10'h3FE, 10'h000,1,0,4'd12);
        step("soft_over_all",  0,1,0,1, 1,4'd5,0, 10'h031, 10'h031,1,0,4'd13);
        step("halt_alone",     0,0,1,0, 0,4'd0,0, 10'h031, 10'h032,1,0,4'd14);
        step("start_in_run",   1,0,0,0, 0,4'd0,0, 10'h100, 10'h033,1,0,4'd15);
        step("start_and_soft", 1,1,0,0, 0,4'd0,0, 10'h100, 10'h100,1,0,4'd15);
        step("sat1",           0,0,0,0, 0,4'd0,0, 10'h100, 10'h101,1,0,4'd15);
        step("sat2",           0,0,0,0, 0,4'd0,0, 10'h100, 10'h102,1,0,4'd15);
        step("sat3",           0,0,0,0, 0,4'd0,0, 10'h100, 10'h103,1,0,4'd15);
        step("sat4",           0,0,0,0, 0,4'd0,0, 10'h100, 10'h104,1,0,4'd15);

        // Halt and restart
        step("halt_sat",       0,1,1,0, 0,4'd0,0, 10'h100, 10'h104,0,1,4'd15);
        step("start_030",      1,0,0,0, 0,4'd0,0, 10'h030, 10'h030,1,0,4'd0);
        step("run_031",        0,0,0,0, 0,4'd0,0, 10'h030, 10'h031,1,0,4'd1);
        step("run_032",        0,0,0,0, 0,4'd0,0, 10'h030, 10'h032,1,0,4'd2);
        step("run_033",        0,0,0,0, 0,4'd0,0, 10'h030, 10'h033,1,0,4'd3);
        step("halt_033",       0,1,1,0, 0,4'd0,0, 10'h030, 10'h033,0,1,4'd4);
        for (int i = 0; i < 5; i++) begin
            step("halted_frozen", 0,1,0,i[0], 1,4'd7,i[1], 10'h030, 10'h033,0,1,4'd4);
        end
        step("restart_200",    1,0,0,0, 0,4'd0,0, 10'h200, 10'h200,1,0,4'd0);
        step("restart_run",    0,0,0,0, 0,4'd0,0, 10'h200, 10'h201,1,0,4'd1);

        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
